cpu2fpga_pcie: RTL

- Host-to-FPGA counterpart of the FPGA-to-host PCIe ring path.
- Watches the CPU-side ring buffer, where the CPU advances the tail and the FPGA owns the head.
- Issues read-data-mover descriptors to copy pending 64-B entries into a local BRAM, then streams them to the pipeline as 512-bit lines.
- Publishes the new head once the lines are drained.

---
 rtl/cpu2fpga_pcie_pkg.sv | 28 ++
 rtl/cpu2fpga_pcie_lbuf_bram.sv | 29 ++
 rtl/cpu2fpga_pcie.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu2fpga_pcie_pkg.sv
// Shared definitions for the host-to-FPGA ring fetch path: descriptor layout,
// local buffer geometry and controller states.
package cpu2fpga_pcie_pkg;

    localparam int          LINE_W       = 512;
    localparam int          DESC_W       = 174;
    localparam int          DWORDS_W     = 18;
    localparam logic [31:0] EP_BASE_ADDR = 32'h0004_0000;

    // The mover's descriptor is 173 bits of content; the extra MSB is always zero.
    typedef struct packed {
        logic [14:0]         rsvd_hi;
        logic [7:0]          id;
        logic [4:0]          rsvd_lo;
        logic [DWORDS_W-1:0] dwords;
        logic [63:0]         dst;
        logic [63:0]         src;
    } desc_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DESC,
        S_DESC_WRAP,
        S_WAIT,
        S_DRAIN
    } state_t;

endpackage

// File: rtl/cpu2fpga_pcie_lbuf_bram.sv
// Simple dual-port line buffer: one write port, one read port with a
// single-cycle registered read.
module cpu2fpga_pcie_lbuf_bram
    import cpu2fpga_pcie_pkg::*;
#(
    parameter int DEPTH  = 512,
    parameter int AWIDTH = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [LINE_W-1:0] wdata,
    input  logic              re,
    input  logic [AWIDTH-1:0] raddr,
    output logic [LINE_W-1:0] rdata
);

    logic [LINE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/cpu2fpga_pcie.sv
// Fetches pending host ring entries into a local BRAM via read-data-mover
// descriptors, streams them out as 512-bit lines, then publishes the new head.
module cpu2fpga_pcie #(
    parameter int          LBUF_DEPTH   = 512,
    parameter int          LBUF_AWIDTH  = 9,
    parameter int          RB_AWIDTH    = 9,
    parameter int          MAX_BURST    = 64,
    parameter logic [31:0] EP_BASE_ADDR = cpu2fpga_pcie_pkg::EP_BASE_ADDR,
    parameter logic [7:0]  DESC_ID      = 8'h01
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 en,
    input  logic [RB_AWIDTH-1:0]                 tail,
    input  logic [63:0]                          kmem_addr,
    input  logic [30:0]                          rb_size,
    output logic [RB_AWIDTH-1:0]                 out_head,
    output logic                                 dma_done,
    input  logic                                 rddm_desc_ready,
    output logic                                 rddm_desc_valid,
    output logic [cpu2fpga_pcie_pkg::DESC_W-1:0] rddm_desc_data,
    input  logic                                 lrb_write,
    input  logic [LBUF_AWIDTH-1:0]               lrb_address,
    input  logic [cpu2fpga_pcie_pkg::LINE_W-1:0] lrb_writedata,
    output logic                                 out_valid,
    output logic [cpu2fpga_pcie_pkg::LINE_W-1:0] out_data,
    output logic                                 out_last,
    input  logic                                 out_ready
);

    import cpu2fpga_pcie_pkg::*;

    localparam int CW = LBUF_AWIDTH + 1;

    state_t            state;
    logic [CW-1:0]     size_r, cnt, rd_ptr;
    logic              wrap_r;
    logic [31:0]       head32, tail32, rbs32, avail, size_c, sum_c, sum_r, lo32;
    logic              wrap_c, wr_ok, rd_issue, pop;
    logic [63:0]       src_head, src_base, dst_base;
    logic [RB_AWIDTH-1:0] new_head;
    logic [LINE_W-1:0] rdata, buf0, buf1;
    logic              last0, last1, rd_vld_p1, rd_last_p1;
    logic [1:0]        occ;

    function automatic desc_t make_desc(input logic [31:0] lines,
                                        input logic [63:0] dst,
                                        input logic [63:0] src);
        desc_t d;
        d        = '0;
        d.id     = DESC_ID;
        d.dwords = DWORDS_W'(lines << 4);
        d.dst    = dst;
        d.src    = src;
        return d;
    endfunction

    assign head32   = 32'(out_head);
    assign tail32   = 32'(tail);
    assign rbs32    = {1'b0, rb_size};
    assign avail    = (tail32 >= head32) ? tail32 - head32 : rbs32 - head32 + tail32;
    assign size_c   = (avail > 32'(MAX_BURST)) ? 32'(MAX_BURST) : avail;
    assign sum_c    = head32 + size_c;
    assign wrap_c   = sum_c > rbs32;
    assign lo32     = rbs32 - head32;
    assign sum_r    = head32 + 32'(size_r);
    assign new_head = RB_AWIDTH'((sum_r >= rbs32) ? sum_r - rbs32 : sum_r);
    assign src_head = kmem_addr + (64'(out_head) << 6) + 64'd64;
    assign src_base = kmem_addr + 64'd64;
    assign dst_base = 64'(EP_BASE_ADDR);

    assign wr_ok    = (state == S_WAIT) && lrb_write && ({1'b0, lrb_address} < size_r);
    assign pop      = (occ != 2'd0) && out_ready;
    // Keep at most two lines buffered or in flight so backpressure never loses data.
    assign rd_issue = (state == S_DRAIN) && (rd_ptr < size_r) &&
                      ((3'(occ) + 3'(rd_vld_p1)) <= (3'd1 + 3'(pop)));

    assign out_valid = (occ != 2'd0);
    assign out_data  = buf0;
    assign out_last  = out_valid && last0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            rddm_desc_valid <= 1'b0;
            rddm_desc_data  <= '0;
            out_head        <= '0;
            dma_done        <= 1'b0;
            size_r          <= '0;
            wrap_r          <= 1'b0;
            cnt             <= '0;
            rd_ptr          <= '0;
        end else begin
            dma_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (en && avail != 32'd0) begin
                        size_r          <= CW'(size_c);
                        wrap_r          <= wrap_c;
                        cnt             <= '0;
                        rd_ptr          <= '0;
                        rddm_desc_valid <= 1'b1;
                        rddm_desc_data  <= make_desc(wrap_c ? lo32 : size_c, dst_base, src_head);
                        state           <= S_DESC;
                    end
                end
                S_DESC: begin
                    if (rddm_desc_ready) begin
                        if (wrap_r) begin
                            rddm_desc_data <= make_desc(32'(size_r) - lo32,
                                                        dst_base + (64'(lo32) << 6), src_base);
                            state          <= S_DESC_WRAP;
                        end else begin
                            rddm_desc_valid <= 1'b0;
                            state           <= S_WAIT;
                        end
                    end
                end
                S_DESC_WRAP: begin
                    if (rddm_desc_ready) begin
                        rddm_desc_valid <= 1'b0;
                        state           <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == size_r) begin
                        state <= S_DRAIN;
                    end else if (wr_ok) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (rd_issue) begin
                        rd_ptr <= rd_ptr + 1'b1;
                    end
                    if (pop && out_last) begin
                        out_head <= new_head;
                        dma_done <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // BRAM read -> p1 -> two-entry skid buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_p1 <= 1'b0;
            occ       <= 2'd0;
        end else begin
            rd_vld_p1 <= rd_issue;
            case (occ)
                2'd0:    if (rd_vld_p1) occ <= 2'd1;
                2'd1:    if (rd_vld_p1 && !pop) occ <= 2'd2;
                         else if (!rd_vld_p1 && pop) occ <= 2'd0;
                default: if (pop) occ <= 2'd1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        rd_last_p1 <= (rd_ptr == size_r - 1'b1);
        case (occ)
            2'd0: begin
                if (rd_vld_p1) begin
                    buf0  <= rdata;
                    last0 <= rd_last_p1;
                end
            end
            2'd1: begin
                if (rd_vld_p1 && pop) begin
                    buf0  <= rdata;
                    last0 <= rd_last_p1;
                end else if (rd_vld_p1) begin
                    buf1  <= rdata;
                    last1 <= rd_last_p1;
                end
            end
            default: begin
                if (pop) begin
                    buf0  <= buf1;
                    last0 <= last1;
                end
            end
        endcase
    end

    cpu2fpga_pcie_lbuf_bram #(
        .DEPTH  (LBUF_DEPTH),
        .AWIDTH (LBUF_AWIDTH)
    ) u_lbuf (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (lrb_address),
        .wdata (lrb_writedata),
        .re    (rd_issue),
        .raddr (rd_ptr[LBUF_AWIDTH-1:0]),
        .rdata (rdata)
    );

endmodule
